// File: rtl/pipe_scoreboard_pkg.sv
// rtl/pipe_scoreboard_pkg.sv - shared scoreboard configuration defaults and sizing helper
package pipe_scoreboard_pkg;

    localparam int SB_NREG    = 32;
    localparam int SB_LAT_MAX = 7;
    localparam int SB_CNT_W   = 16;

    // Countdown must hold LAT_MAX+1 so the writeback-only variant fits.
    function automatic int cnt_width(input int lat_max);
        return $clog2(lat_max + 2);
    endfunction

endpackage

// File: rtl/pipe_sb_cnt.sv
// rtl/pipe_sb_cnt.sv - per-register result countdown with load, decrement and busy flag
module pipe_sb_cnt #(
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic [CW-1:0] o_cnt,
    output logic          o_busy
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - issue scoreboard with RAW/WAW interlock and stall statistics; SB_NO_BYPASS_EN selects writeback-only results
module pipe_scoreboard
    import pipe_scoreboard_pkg::*;
#(
    parameter int NREG    = SB_NREG,
    parameter int LAT_MAX = SB_LAT_MAX,
    parameter int CNT_W   = SB_CNT_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_issue_valid,
    input  logic [$clog2(NREG)-1:0]      i_issue_rs1,
    input  logic [$clog2(NREG)-1:0]      i_issue_rs2,
    input  logic                         i_issue_rs1_used,
    input  logic                         i_issue_rs2_used,
    input  logic [$clog2(NREG)-1:0]      i_issue_rd,
    input  logic                         i_issue_rd_we,
    input  logic [$clog2(LAT_MAX+1)-1:0] i_issue_lat,
    input  logic                         i_flush,
    input  logic                         i_stat_clr,
    output logic                         o_issue_ready,
    output logic                         o_raw_stall,
    output logic                         o_waw_stall,
    output logic [NREG-1:0]              o_busy,
    output logic [CNT_W-1:0]             o_stall_cnt
);

    localparam int RW = $clog2(NREG);
    localparam int CW = cnt_width(LAT_MAX);

    logic [CW-1:0]    cnt [NREG];
    logic [NREG-1:0]  busy;
    logic [CW-1:0]    lat_ext;
    logic [CW-1:0]    lat_clamp;
    logic [CW-1:0]    load_val;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             raw;
    logic             waw;
    logic             accept;
    logic             load_en;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    always_comb begin
        lat_ext   = CW'(i_issue_lat);
        lat_clamp = (lat_ext > CW'(LAT_MAX)) ? CW'(LAT_MAX) : lat_ext;
`ifdef SB_NO_BYPASS_EN
        load_val  = lat_clamp + CW'(1);
`else
        load_val  = lat_clamp;
`endif
    end

    // A source is ready in the cycle its countdown hits zero.
    always_comb begin
        rs1_hit = i_issue_rs1_used && (i_issue_rs1 != '0) && (cnt[i_issue_rs1] != '0);
        rs2_hit = i_issue_rs2_used && (i_issue_rs2 != '0) && (cnt[i_issue_rs2] != '0);
        raw     = i_issue_valid && (rs1_hit || rs2_hit);
        waw     = i_issue_valid && i_issue_rd_we && (i_issue_rd != '0)
                  && (cnt[i_issue_rd] > load_val);
        accept  = i_issue_valid && !raw && !waw && !i_flush;
        load_en = accept && i_issue_rd_we && (i_issue_rd != '0);
        stall   = i_issue_valid && (raw || waw) && !i_flush;
    end

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        pipe_sb_cnt #(
            .CW (CW)
        ) u_cnt (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_load     (load_en && (i_issue_rd == RW'(r))),
            .i_load_val (load_val),
            .o_cnt      (cnt[r]),
            .o_busy     (busy[r])
        );
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_stat_clr) begin
            stall_cnt_d = '0;
        end else if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_issue_ready = !raw && !waw && !i_flush;
    assign o_raw_stall   = raw;
    assign o_waw_stall   = waw;
    assign o_busy        = busy;
    assign o_stall_cnt   = stall_cnt_q;

endmodule
